// File: rtl/ptl_arb_pkg.sv
// Shared types and the bias-to-holdoff table for the PTL splitter pulse arbiter.
// Holdoff values are in clock cycles at 1 ps/cycle, rounded up from the splitter recovery delay.
package ptl_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int BIAS_N   = 12;
  localparam int BIAS_MAX = 11;

  // Index 0..11 corresponds to 70%..125% bias in 5% steps.
  function automatic logic [4:0] hold_lut(input logic [3:0] idx);
    logic [4:0] cycles;
    case (idx)
      4'd0:    cycles = 5'd17;
      4'd1:    cycles = 5'd14;
      4'd2:    cycles = 5'd12;
      4'd3:    cycles = 5'd11;
      4'd4:    cycles = 5'd10;
      4'd5:    cycles = 5'd9;
      4'd6:    cycles = 5'd8;
      4'd7:    cycles = 5'd8;
      4'd8:    cycles = 5'd7;
      4'd9:    cycles = 5'd7;
      4'd10:   cycles = 5'd6;
      default: cycles = 5'd6;
    endcase
    return cycles;
  endfunction

endpackage

// File: rtl/ptl_spl_pulse_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping cyclically.
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic                     valid,
  output logic [$clog2(N_REQ)-1:0] winner
);

  localparam int IW = $clog2(N_REQ);

  logic [2*N_REQ-1:0] dbl;
  logic [2*N_REQ-1:0] rot;
  int                 pos;

  assign dbl = {req, req};
  assign rot = dbl >> ptr;

  // rot[i] is the request i slots after ptr, so the lowest set bit is the RR winner.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    pos    = 0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!valid && rot[i]) begin
        valid = 1'b1;
        pos   = int'(ptr) + i;
        if (pos >= N_REQ) pos = pos - N_REQ;
        winner = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/ptl_spl_pulse_arbiter.sv
// Round-robin arbiter that shares one PTL splitter input among N_REQ requesters, emitting one
// single-cycle pulse per grant followed by a bias-dependent holdoff so the splitter can recover.
module ptl_spl_pulse_arbiter
  import ptl_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int MIN_GAP = 2,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [3:0]               bias_sel,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  output logic                     spl_a,
  output logic                     busy,
  output logic                     bias_err,
  output logic [CNT_W-1:0]         fire_cnt
);

  localparam int IW      = $clog2(N_REQ);
  localparam int HOLD_CW = $clog2(17 + MIN_GAP);

  state_t             state;
  logic [IW-1:0]      ptr;
  logic [IW-1:0]      winner_q;
  logic [3:0]         bias_q;
  logic [HOLD_CW-1:0] hold;

  logic               pick_valid;
  logic [IW-1:0]      pick_idx;

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req    (req),
    .ptr    (ptr),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      winner_q <= '0;
      bias_q   <= '0;
      hold     <= '0;
      gnt      <= '0;
      gnt_id   <= '0;
      spl_a    <= 1'b0;
      busy     <= 1'b0;
      bias_err <= 1'b0;
      fire_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bias_sel > 4'(BIAS_MAX)) begin
            bias_q   <= 4'(BIAS_MAX);
            bias_err <= 1'b1;
          end else begin
            bias_q <= bias_sel;
          end
          if (pick_valid) begin
            winner_q <= pick_idx;
            ptr      <= (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + IW'(1);
            busy     <= 1'b1;
            state    <= FIRE;
          end
        end
        FIRE: begin
          spl_a    <= 1'b1;
          gnt      <= N_REQ'(1) << winner_q;
          gnt_id   <= winner_q;
          fire_cnt <= fire_cnt + CNT_W'(1);
          hold     <= HOLD_CW'(hold_lut(bias_q)) + HOLD_CW'(MIN_GAP - 1);
          state    <= HOLD;
        end
        HOLD: begin
          spl_a <= 1'b0;
          gnt   <= '0;
          // Leaving on the edge that takes hold to zero gives a pulse period of 1+LUT+MIN_GAP.
          if (hold <= HOLD_CW'(1)) begin
            hold  <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            hold <= hold - HOLD_CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          spl_a <= 1'b0;
          gnt   <= '0;
        end
      endcase
    end
  end

endmodule
